// File: rtl/aq_gemac_miim_slave_if.sv
// Register-file strobe bus between the MIIM responder (master) and a register bank (slave).
interface aq_gemac_miim_slave_if;
  logic [4:0]  reg_address;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        busy;

  modport master (
    output reg_address, reg_re, reg_we, reg_wdata, busy,
    input  reg_rdata
  );

  modport slave (
    input  reg_address, reg_re, reg_we, reg_wdata, busy,
    output reg_rdata
  );
endinterface

// File: rtl/aq_gemac_miim_slave.sv
// Clause 22 MDIO responder, MDC/MDIO oversampled on sys_clk, register-file strobe outputs.
// Define MIIM_PRE_SUP_EN to accept a 1-bit preamble after a cleanly completed frame.
module aq_gemac_miim_slave #(
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         mdc,
  input  logic                         mdio_i,
  output logic                         mdio_o,
  output logic                         mdio_oe,
  input  logic [4:0]                   phy_address,
  aq_gemac_miim_slave_if.master        reg_bus
);

  localparam logic [5:0] PreLen = 6'(PREAMBLE_LEN);

  typedef enum logic [3:0] {
    StIdle, StSt, StOp, StPhyad, StRegad, StTa, StRdata, StWdata, StSkip
  } state_e;

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
  logic                   mdc_d_q;
  logic                   mdc_s, mdio_s, rise, fall, pre_go;

  state_e      state_q;
  logic [5:0]  pre_cnt_q;
  logic [4:0]  cnt_q;
  logic [15:0] shift_q;
  logic        op_hi_q, is_read_q;
  logic        re_pend_q, re_p1_q, re_p2_q;
  logic        mdio_o_q, mdio_oe_q, reg_re_q, reg_we_q, busy_q;
  logic [4:0]  reg_address_q;
  logic [15:0] reg_wdata_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_d_q     <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
      mdc_d_q     <= mdc_s;
    end
  end

  assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
  assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
  assign rise   = mdc_s & ~mdc_d_q;
  assign fall   = ~mdc_s & mdc_d_q;

`ifdef MIIM_PRE_SUP_EN
  logic pre_ok_q, frame_done, frame_abort;

  assign frame_done  = (rise && state_q == StWdata && cnt_q == 5'd15) ||
                       (rise && state_q == StSkip && cnt_q == 5'd17) ||
                       (fall && state_q == StRdata && cnt_q == 5'd16);
  assign frame_abort = rise && ((state_q == StSt && !mdio_s) ||
                                (state_q == StOp && cnt_q == 5'd1 && op_hi_q == mdio_s));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)           pre_ok_q <= 1'b0;
    else if (frame_abort) pre_ok_q <= 1'b0;
    else if (frame_done)  pre_ok_q <= 1'b1;
  end

  assign pre_go = (pre_cnt_q == PreLen) || (pre_ok_q && (pre_cnt_q != 6'd0));
`else
  assign pre_go = (pre_cnt_q == PreLen);
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      shift_q       <= '0;
      op_hi_q       <= 1'b0;
      is_read_q     <= 1'b0;
      re_pend_q     <= 1'b0;
      re_p1_q       <= 1'b0;
      re_p2_q       <= 1'b0;
      mdio_o_q      <= 1'b1;
      mdio_oe_q     <= 1'b0;
      reg_re_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      reg_address_q <= '0;
      reg_wdata_q   <= '0;
    end else begin
      reg_we_q  <= 1'b0;
      re_pend_q <= 1'b0;
      reg_re_q  <= re_pend_q;
      re_p1_q   <= reg_re_q;
      re_p2_q   <= re_p1_q;
      // Read data is guaranteed valid two cycles after the strobe.
      if (re_p2_q) shift_q <= reg_bus.reg_rdata;

      case (state_q)
        StIdle: if (rise) begin
          if (mdio_s) begin
            if (pre_cnt_q != PreLen) pre_cnt_q <= pre_cnt_q + 6'd1;
          end else begin
            pre_cnt_q <= '0;
            if (pre_go) state_q <= StSt;
          end
        end
        StSt: if (rise) begin
          if (mdio_s) begin
            state_q <= StOp;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StOp: if (rise) begin
          if (cnt_q == 5'd0) begin
            op_hi_q <= mdio_s;
            cnt_q   <= 5'd1;
          end else begin
            cnt_q <= '0;
            if (op_hi_q != mdio_s) begin
              is_read_q <= op_hi_q;
              state_q   <= StPhyad;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StPhyad: if (rise) begin
          shift_q <= {shift_q[14:0], mdio_s};
          if (cnt_q == 5'd4) begin
            cnt_q   <= '0;
            state_q <= ({shift_q[3:0], mdio_s} == phy_address) ? StRegad : StSkip;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StRegad: if (rise) begin
          shift_q <= {shift_q[14:0], mdio_s};
          if (cnt_q == 5'd4) begin
            cnt_q         <= '0;
            reg_address_q <= {shift_q[3:0], mdio_s};
            re_pend_q     <= is_read_q;
            state_q       <= StTa;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StTa: begin
          if (rise) begin
            if (cnt_q == 5'd1) begin
              cnt_q   <= '0;
              state_q <= is_read_q ? StRdata : StWdata;
            end else begin
              cnt_q <= 5'd1;
            end
          end else if (fall && is_read_q && cnt_q == 5'd1) begin
            mdio_oe_q <= 1'b1;
            mdio_o_q  <= 1'b0;
          end
        end
        StRdata: begin
          if (fall) begin
            if (cnt_q == 5'd16) begin
              mdio_oe_q <= 1'b0;
              mdio_o_q  <= 1'b1;
              busy_q    <= 1'b0;
              cnt_q     <= '0;
              state_q   <= StIdle;
            end else begin
              mdio_o_q <= shift_q[15];
              shift_q  <= {shift_q[14:0], 1'b0};
            end
          end else if (rise) begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StWdata: if (rise) begin
          shift_q <= {shift_q[14:0], mdio_s};
          if (cnt_q == 5'd15) begin
            reg_wdata_q <= {shift_q[14:0], mdio_s};
            reg_we_q    <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StSkip: if (rise) begin
          if (cnt_q == 5'd17) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mdio_o              = mdio_o_q;
  assign mdio_oe             = mdio_oe_q;
  assign reg_bus.reg_address = reg_address_q;
  assign reg_bus.reg_re      = reg_re_q;
  assign reg_bus.reg_we      = reg_we_q;
  assign reg_bus.reg_wdata   = reg_wdata_q;
  assign reg_bus.busy        = busy_q;

endmodule

// File: tb/tb_aq_gemac_miim_slave.sv
// Randomised MDIO station-manager bench with a register-file model and strobe scoreboard.
module tb_aq_gemac_miim_slave;

  localparam int PreLen = 32;
`ifdef MIIM_PRE_SUP_EN
  localparam bit Sup = 1'b1;
`else
  localparam bit Sup = 1'b0;
`endif
  localparam logic [1:0] KWe = 2'd0, KRe = 2'd1, KRd = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst_n, mdc, m_oe, m_val;
  logic        mdio_o, mdio_oe, pad;
  logic [4:0]  phy_address;
  logic [15:0] tb_rf [32];
  logic [15:0] mem [32];
  logic        m_pre_ok;
  logic        oe_seen;
  exp_t        exp_q [$];
  logic [15:0] obs_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 sys_clk = ~sys_clk;

  assign pad = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

  aq_gemac_miim_slave_if bus ();
  assign bus.reg_rdata = tb_rf[bus.reg_address];

  aq_gemac_miim_slave dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .mdc         (mdc),
    .mdio_i      (pad),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .phy_address (phy_address),
    .reg_bus     (bus)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [4:0] addr, input logic [15:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT strobes or the master completes a read.
  initial begin
    exp_t e;
    logic [15:0] w;
    for (int i = 0; i < 32; i++) tb_rf[i] = init_val(i);
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1) begin
        if (mdio_oe) oe_seen = 1'b1;
        if (bus.reg_re || bus.reg_we) begin
          check("re_we_exclusive", 32'(bus.reg_re & bus.reg_we), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got re=%0b we=%0b addr=%0h, required none",
                     bus.reg_re, bus.reg_we, bus.reg_address);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", 32'(bus.reg_we ? KWe : KRe), 32'(e.kind));
            check("strobe_addr", 32'(bus.reg_address), 32'(e.addr));
            if (bus.reg_we) check("strobe_wdata", 32'(bus.reg_wdata), 32'(e.data));
          end
          if (bus.reg_we) tb_rf[bus.reg_address] = bus.reg_wdata;
        end
        if (obs_q.size() > 0) begin
          w = obs_q.pop_front();
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read_data: got %0h, required none", w);
          end else begin
            e = exp_q.pop_front();
            check("read_kind", 32'(KRd), 32'(e.kind));
            check("read_data", 32'(w), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_mdio_o"},  32'(mdio_o), 32'd1);
    check({tag, "_mdio_oe"}, 32'(mdio_oe), 32'd0);
    check({tag, "_reg_re"},  32'(bus.reg_re), 32'd0);
    check({tag, "_reg_we"},  32'(bus.reg_we), 32'd0);
    check({tag, "_reg_addr"}, 32'(bus.reg_address), 32'd0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
    check({tag, "_busy"},    32'(bus.busy), 32'd0);
  endtask

  // One MDC period: falling edge (master drive point), then rising edge after half a period.
  task automatic bit_cycle(input logic drv, input logic v, output logic smp);
    @(negedge sys_clk);
    mdc   = 1'b0;
    m_oe  = drv;
    m_val = v;
    repeat (8) @(negedge sys_clk);
    smp = pad;
    mdc = 1'b1;
    repeat (7) @(negedge sys_clk);
  endtask

  task automatic frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phyad, input logic [4:0] regad,
                       input logic [15:0] wdata, input int abort_at);
    logic        s, acc_pre, busy_exp, respond;
    logic [15:0] rword = '0;
    // Reference model of the frame outcome.
    acc_pre  = (pre_len >= PreLen) || (Sup && m_pre_ok && pre_len >= 1);
    busy_exp = acc_pre && st == 2'b01 && (op == 2'b10 || op == 2'b01);
    if (acc_pre && !busy_exp) m_pre_ok = 1'b0;
    respond  = busy_exp && op == 2'b10 && phyad == phy_address;
    if (busy_exp) begin
      m_pre_ok = 1'b1;
      if (phyad == phy_address) begin
        if (op == 2'b01) begin
          push_exp(KWe, regad, wdata);
          mem[regad] = wdata;
        end else begin
          push_exp(KRe, regad, 16'h0);
          if (abort_at < 0) push_exp(KRd, regad, mem[regad]);
        end
      end
    end
    if (respond && abort_at >= 0) m_pre_ok = 1'b0;

    oe_seen = 1'b0;
    repeat (pre_len) bit_cycle(1'b1, 1'b1, s);
    bit_cycle(1'b1, st[1], s);
    bit_cycle(1'b1, st[0], s);
    bit_cycle(1'b1, op[1], s);
    bit_cycle(1'b1, op[0], s);
    for (int i = 4; i >= 0; i--) bit_cycle(1'b1, phyad[i], s);
    for (int i = 4; i >= 0; i--) bit_cycle(1'b1, regad[i], s);
    if (op == 2'b10) begin
      bit_cycle(1'b0, 1'b1, s);
      check("busy_in_ta", 32'(bus.busy), 32'(busy_exp));
      if (respond) check("ta1_oe_low", 32'(mdio_oe), 32'd0);
      bit_cycle(1'b0, 1'b1, s);
      if (respond) check("ta2_zero", 32'(s), 32'd0);
      for (int i = 15; i >= 0; i--) begin
        if (respond && i == abort_at) begin
          @(negedge sys_clk);
          mdc = 1'b0;
          repeat (4) @(negedge sys_clk);
          check("oe_before_reset", 32'(mdio_oe), 32'd1);
          rst_n = 1'b0;
          #1;
          check_reset_values("midreset");
          repeat (3) @(negedge sys_clk);
          rst_n = 1'b1;
          repeat (4) @(negedge sys_clk);
          check("queue_drained_abort", 32'(exp_q.size()), 32'd0);
          exp_q.delete();
          return;
        end
        bit_cycle(1'b0, 1'b1, s);
        rword[i] = s;
      end
      if (respond) obs_q.push_back(rword);
    end else begin
      bit_cycle(1'b1, 1'b1, s);
      check("busy_in_ta", 32'(bus.busy), 32'(busy_exp));
      bit_cycle(1'b1, 1'b0, s);
      for (int i = 15; i >= 0; i--) bit_cycle(1'b1, wdata[i], s);
    end
    // Trailing falling edge: the responder releases the line here.
    @(negedge sys_clk);
    mdc  = 1'b0;
    m_oe = 1'b0;
    repeat (8) @(negedge sys_clk);
    check("oe_released", 32'(mdio_oe), 32'd0);
    check("busy_end", 32'(bus.busy), 32'd0);
    if (!respond) check("oe_never_driven", 32'(oe_seen), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [1:0] st, op;
    logic [4:0] phyad;
    int         r, pl;
    rst_n       = 1'b0;
    mdc         = 1'b0;
    m_oe        = 1'b0;
    m_val       = 1'b1;
    phy_address = 5'h01;
    m_pre_ok    = 1'b0;
    oe_seen     = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    repeat (5) @(negedge sys_clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    frame(32, 2'b01, 2'b01, 5'h01, 5'h04, 16'hA5C3, -1);
    check("write_reg_address", 32'(bus.reg_address), 32'h04);
    check("write_reg_wdata", 32'(bus.reg_wdata), 32'hA5C3);

    frame(32, 2'b01, 2'b01, 5'h01, 5'h02, 16'h796D, -1);
    frame(32, 2'b01, 2'b10, 5'h01, 5'h02, 16'h0000, -1);
    check("read_reg_address", 32'(bus.reg_address), 32'h02);

    frame(32, 2'b01, 2'b10, 5'h03, 5'h02, 16'h0000, -1);
    frame(32, 2'b01, 2'b10, 5'h01, 5'h04, 16'h0000, -1);

    frame(31, 2'b01, 2'b01, 5'h01, 5'h05, 16'h1234, -1);
    frame(32, 2'b01, 2'b11, 5'h01, 5'h06, 16'hBEEF, -1);
    frame(32, 2'b01, 2'b01, 5'h01, 5'h06, 16'h0F0F, -1);
    frame(32, 2'b00, 2'b01, 5'h01, 5'h07, 16'hFFFF, -1);
    frame(32, 2'b01, 2'b10, 5'h01, 5'h06, 16'h0000, -1);

    frame(32, 2'b01, 2'b10, 5'h01, 5'h02, 16'h0000, 7);
    frame(32, 2'b01, 2'b10, 5'h01, 5'h04, 16'h0000, -1);

    frame(32, 2'b01, 2'b01, 5'h01, 5'h08, 16'hC001, -1);
    frame(1, 2'b01, 2'b01, 5'h01, 5'h09, 16'hD00D, -1);
    frame(32, 2'b01, 2'b10, 5'h01, 5'h09, 16'h0000, -1);

    phy_address = 5'($urandom_range(0, 31));
    for (int n = 0; n < 22; n++) begin
      r     = int'($urandom_range(0, 9));
      st    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
      op    = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r[0] ? 2'b10 : 2'b01);
      phyad = ($urandom_range(0, 3) != 0) ? phy_address : 5'($urandom_range(0, 31));
      pl    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 32;
      frame(pl, st, op, phyad, 5'($urandom_range(0, 31)), 16'($urandom), -1);
    end

    check("final_queue_empty", 32'(exp_q.size() + obs_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
